dmem_port_responder: RTL

- Memory-side responder for the data-memory request/data-phase protocol driven by the memory read stage.
- Accepts one request per cycle on the request channel (valid/ready), performs sized byte writes into a dual-bank 64-bit word store, and returns read data in order on the data-phase channel (valid/ready).
- Sits between the pipeline's data-memory initiators and the backing data store. Used as the functional data memory in simulation and synthesis.

---
 rtl/dmem_port_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_port_responder.sv
// Data-memory responder: sized byte writes into even/odd 64-bit word banks, in-order read responses.
// Optional DMEM_RSP_STALL_INJECT_EN adds LFSR-driven back-pressure on both channels.
module dmem_port_responder #(
  parameter int unsigned DDATAW      = 64,
  parameter int unsigned DSIZEW      = 4,
  parameter int unsigned DADDRW      = 32,
  parameter int unsigned MEMAW       = 10,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned RSPQ_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rmem_valid,
  output logic              rmem_ready,
  input  logic [DADDRW-1:0] rmem_address,
  input  logic              rmem_wr_en,
  input  logic [DDATAW-1:0] rmem_wr_data,
  input  logic [DSIZEW-1:0] rmem_wr_size,
  output logic              rmem_dp_valid,
  input  logic              rmem_dp_ready,
  output logic [DDATAW-1:0] rmem_dp_read_data
);

  localparam int unsigned BANKW      = MEMAW - 1;
  localparam int unsigned BANK_WORDS = 1 << BANKW;
  localparam int unsigned CNTW       = $clog2(RSPQ_DEPTH + 1);
  localparam int unsigned PTRW       = $clog2(RSPQ_DEPTH);

  logic reset_q;
  logic stall;
  logic fire, wr_fire, rd_fire, pop;
  logic [CNTW-1:0] outstanding;

  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

`ifdef DMEM_RSP_STALL_INJECT_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------------------------------------------------------- handshake
  logic [PTRW:0] wr_ptr, rd_ptr;
  logic          fifo_empty;
  logic [DDATAW-1:0] fifo_mem [RSPQ_DEPTH];

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign rmem_dp_valid = ~reset & ~fifo_empty & ~stall;
  assign pop           = rmem_dp_valid & rmem_dp_ready;

  // A pop in this cycle frees a slot, so a full responder may still accept.
  assign rmem_ready = ~reset & ~reset_q & ~stall &
                      ((outstanding < CNTW'(RSPQ_DEPTH)) | pop);
  assign fire    = rmem_valid & rmem_ready;
  assign wr_fire = fire & rmem_wr_en;
  assign rd_fire = fire & ~rmem_wr_en;

  // ---------------------------------------------------------------- address decode
  logic [MEMAW-1:0] word, word_nx;
  logic [2:0]       off;
  logic [BANKW-1:0] even_idx, odd_idx;
  logic             addr_unused;

  assign word     = rmem_address[MEMAW+2:3];
  assign off      = rmem_address[2:0];
  assign word_nx  = word + MEMAW'(1);
  assign odd_idx  = word[MEMAW-1:1];
  assign even_idx = word[0] ? word_nx[MEMAW-1:1] : word[MEMAW-1:1];
  assign addr_unused = ^{rmem_address[DADDRW-1:MEMAW+3], word_nx[0]};

  // ---------------------------------------------------------------- write lane steering
  logic [3:0]          n_bytes;
  logic [15:0]         span_be;
  logic [2*DDATAW-1:0] span_wdata;
  logic [7:0]          even_be, odd_be;
  logic [DDATAW-1:0]   even_wdata, odd_wdata;

  always_comb begin
    n_bytes = 4'd8;
    if (rmem_wr_size != '0 && rmem_wr_size <= DSIZEW'(8)) begin
      n_bytes = 4'(rmem_wr_size);
    end
    span_be = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      span_be[i] = (i >= 32'(off)) && (i < 32'(off) + 32'(n_bytes));
    end
  end

  assign span_wdata = {{DDATAW{1'b0}}, rmem_wr_data} << {off, 3'b000};
  assign even_be    = word[0] ? span_be[15:8] : span_be[7:0];
  assign odd_be     = word[0] ? span_be[7:0]  : span_be[15:8];
  assign even_wdata = word[0] ? span_wdata[127:64] : span_wdata[63:0];
  assign odd_wdata  = word[0] ? span_wdata[63:0]   : span_wdata[127:64];

  // ---------------------------------------------------------------- banks
  logic [DDATAW-1:0] even_bank [BANK_WORDS];
  logic [DDATAW-1:0] odd_bank  [BANK_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 8; i++) begin
      if (wr_fire && even_be[i]) begin
        even_bank[even_idx][8*i +: 8] <= even_wdata[8*i +: 8];
      end
      if (wr_fire && odd_be[i]) begin
        odd_bank[odd_idx][8*i +: 8] <= odd_wdata[8*i +: 8];
      end
    end
  end

  logic [DDATAW-1:0]   lo_word, hi_word, rd_word;
  logic [2*DDATAW-1:0] rd_span;

  assign lo_word = word[0] ? odd_bank[odd_idx]   : even_bank[even_idx];
  assign hi_word = word[0] ? even_bank[even_idx] : odd_bank[odd_idx];
  assign rd_span = {hi_word, lo_word};
  assign rd_word = rd_span[{off, 3'b000} +: DDATAW];

  // ---------------------------------------------------------------- read valid pipe
  logic              push_valid;
  logic [DDATAW-1:0] push_data;

  generate
    if (RD_LATENCY == 1) begin : g_no_pipe
      assign push_valid = rd_fire;
      assign push_data  = rd_word;
    end else begin : g_pipe
      logic              pipe_v [RD_LATENCY-1];
      logic [DDATAW-1:0] pipe_d [RD_LATENCY-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < RD_LATENCY - 1; i++) begin
            pipe_v[i] <= 1'b0;
          end
        end else begin
          pipe_v[0] <= rd_fire;
          for (int unsigned i = 1; i < RD_LATENCY - 1; i++) begin
            pipe_v[i] <= pipe_v[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        pipe_d[0] <= rd_word;
        for (int unsigned i = 1; i < RD_LATENCY - 1; i++) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end

      assign push_valid = pipe_v[RD_LATENCY-2];
      assign push_data  = pipe_d[RD_LATENCY-2];
    end
  endgenerate

  // ---------------------------------------------------------------- response FIFO
  always_ff @(posedge clk) begin
    if (push_valid) begin
      fifo_mem[wr_ptr[PTRW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_valid) wr_ptr <= wr_ptr + 1'b1;
      if (pop)        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rmem_dp_read_data = (fifo_empty | reset) ? '0 : fifo_mem[rd_ptr[PTRW-1:0]];

  // ---------------------------------------------------------------- outstanding reads
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({rd_fire, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
